// File: rtl/vstu_w_sink_pkg.sv
// ============================================================================
// Module      : vstu_w_sink_pkg
// Description : Shared types and constants for the vector-store write sink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vstu_w_sink_pkg;

    // Struct fields are sized for the widest supported configuration.
    localparam int unsigned AddrWidthMax = 64;
    localparam int unsigned IdWidthMax   = 16;

    localparam logic [1:0] RespOkay     = 2'b00;
    localparam logic [1:0] RespSlvErr   = 2'b10;
    localparam logic [1:0] C_BURST_INCR = 2'b01;

    typedef struct packed {
        logic [IdWidthMax-1:0] id;
        logic [1:0]            resp;
    } vstu_w_sink_b_t;

    typedef struct packed {
        logic [AddrWidthMax-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [IdWidthMax-1:0]   id;
        logic                    err;
    } vstu_w_sink_aw_t;

endpackage

`default_nettype wire

// File: rtl/fifo_v3.sv
// ============================================================================
// Module      : fifo_v3
// Description : Synchronous FIFO, port-compatible subset of common_cells.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_v3 #(
    parameter int unsigned DEPTH = 4,
    parameter type         dtype = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    localparam int unsigned C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned C_CNT_W = $clog2(DEPTH + 1);

    dtype               r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign full_o  = (r_count == C_CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);
    assign w_pop   = pop_i && !empty_o;
    // A pop in the same cycle frees the slot a full FIFO is being pushed into.
    assign w_push  = push_i && (!full_o || w_pop);
    assign data_o  = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == C_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + C_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + C_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + C_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - C_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vstu_w_sink.sv
// ============================================================================
// Module      : vstu_w_sink
// Description : AXI write responder turning W beats into SRAM byte writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vstu_w_sink
    import vstu_w_sink_pkg::*;
#(
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned AxiIdWidth   = 5,
    parameter int unsigned MemAddrWidth = 20,
    parameter int unsigned AwDepth      = 2,
    parameter int unsigned BDepth       = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [AxiAddrWidth-1:0]   aw_addr_i,
    input  logic [7:0]                aw_len_i,
    input  logic [2:0]                aw_size_i,
    input  logic [1:0]                aw_burst_i,
    input  logic [AxiIdWidth-1:0]     aw_id_i,
    input  logic                      aw_valid_i,
    output logic                      aw_ready_o,
    input  logic [AxiDataWidth-1:0]   w_data_i,
    input  logic [AxiDataWidth/8-1:0] w_strb_i,
    input  logic                      w_last_i,
    input  logic                      w_valid_i,
    output logic                      w_ready_o,
    output logic [AxiIdWidth-1:0]     b_id_o,
    output logic [1:0]                b_resp_o,
    output logic                      b_valid_o,
    input  logic                      b_ready_i,
    output logic                      mem_req_o,
    output logic [MemAddrWidth-1:0]   mem_addr_o,
    output logic [AxiDataWidth-1:0]   mem_wdata_o,
    output logic [AxiDataWidth/8-1:0] mem_be_o,
    input  logic                      mem_gnt_i
);

    localparam int unsigned C_OFF_W  = $clog2(AxiDataWidth / 8);
    localparam logic [0:0]  S_IDLE   = 1'b0;
    localparam logic [0:0]  S_BURST  = 1'b1;

    logic [0:0]              r_state;
    logic [0:0]              w_state_next;
    vstu_w_sink_aw_t         w_aw_in;
    vstu_w_sink_aw_t         w_aw_head;
    vstu_w_sink_aw_t         r_burst;
    vstu_w_sink_b_t          w_b_in;
    vstu_w_sink_b_t          w_b_head;
    logic                    w_aw_full;
    logic                    w_aw_empty;
    logic                    w_aw_push;
    logic                    w_aw_pop;
    logic                    w_b_full;
    logic                    w_b_empty;
    logic                    w_b_push;
    logic                    w_b_pop;
    logic [7:0]              r_beat_cnt;
    logic                    w_in_burst;
    logic                    w_strb_zero;
    logic                    w_w_hs;
    logic                    w_is_last;
    logic                    w_last_err;
    logic [AxiAddrWidth-1:0] w_size_mask;
    logic [AxiAddrWidth-1:0] w_beat_addr;
    logic                    w_unused_bits;

    // ------------------------------------------------------------------ AW
    assign aw_ready_o = !rst_i && !w_aw_full;
    assign w_aw_push  = aw_valid_i && aw_ready_o;

    always_comb begin
        w_aw_in      = '0;
        w_aw_in.addr = AddrWidthMax'(aw_addr_i);
        w_aw_in.len  = aw_len_i;
        w_aw_in.size = aw_size_i;
        w_aw_in.id   = IdWidthMax'(aw_id_i);
        w_aw_in.err  = (aw_burst_i != C_BURST_INCR);
    end

    fifo_v3 #(
        .DEPTH (AwDepth),
        .dtype (vstu_w_sink_aw_t)
    ) u_aw_fifo (
        .clk_i   (clk_i),
        .rst_ni  (1'b1),
        .flush_i (rst_i),
        .full_o  (w_aw_full),
        .empty_o (w_aw_empty),
        .data_i  (w_aw_in),
        .push_i  (w_aw_push),
        .data_o  (w_aw_head),
        .pop_i   (w_aw_pop)
    );

    // ------------------------------------------------------------------ W
    assign w_aw_pop    = (r_state == S_IDLE) && !w_aw_empty;
    assign w_in_burst  = (r_state == S_BURST) && !rst_i;
    assign w_strb_zero = (w_strb_i == '0);
    // Zero-strobe beats never touch memory, so they need no grant.
    assign w_ready_o   = w_in_burst && !w_b_full && (mem_gnt_i || w_strb_zero);
    assign mem_req_o   = w_in_burst && w_valid_i && !w_b_full && !w_strb_zero;
    assign w_w_hs      = w_valid_i && w_ready_o;
    assign w_is_last   = (r_beat_cnt == r_burst.len);
    assign w_last_err  = (w_last_i != w_is_last);
    assign w_b_push    = w_w_hs && w_is_last;

    assign w_size_mask = (AxiAddrWidth'(1) << r_burst.size) - AxiAddrWidth'(1);
    assign w_beat_addr = (r_burst.addr[AxiAddrWidth-1:0] & ~w_size_mask)
                       + (AxiAddrWidth'(r_beat_cnt) << r_burst.size);

    assign mem_addr_o  = w_in_burst ? w_beat_addr[MemAddrWidth+C_OFF_W-1:C_OFF_W] : '0;
    assign mem_wdata_o = w_in_burst ? w_data_i : '0;
    assign mem_be_o    = w_in_burst ? w_strb_i : '0;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_aw_empty) w_state_next = S_BURST;
            S_BURST: if (w_b_push)    w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_burst    <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_aw_pop) begin
                r_burst    <= w_aw_head;
                r_beat_cnt <= '0;
            end else if (w_w_hs) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
                if (w_last_err) begin
                    r_burst.err <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------ B
    always_comb begin
        w_b_in      = '0;
        w_b_in.id   = r_burst.id;
        w_b_in.resp = (r_burst.err || w_last_err) ? RespSlvErr : RespOkay;
    end

    fifo_v3 #(
        .DEPTH (BDepth),
        .dtype (vstu_w_sink_b_t)
    ) u_b_fifo (
        .clk_i   (clk_i),
        .rst_ni  (1'b1),
        .flush_i (rst_i),
        .full_o  (w_b_full),
        .empty_o (w_b_empty),
        .data_i  (w_b_in),
        .push_i  (w_b_push),
        .data_o  (w_b_head),
        .pop_i   (w_b_pop)
    );

    assign b_valid_o = !w_b_empty && !rst_i;
    assign w_b_pop   = b_valid_o && b_ready_i;
    assign b_id_o    = b_valid_o ? w_b_head.id[AxiIdWidth-1:0] : '0;
    assign b_resp_o  = b_valid_o ? w_b_head.resp : '0;

    assign w_unused_bits = ^{w_beat_addr, r_burst, w_b_head};

endmodule

`default_nettype wire

// File: tb/tb_vstu_w_sink.sv
// ============================================================================
// Module      : tb_vstu_w_sink
// Description : Directed self-checking bench for vstu_w_sink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vstu_w_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] aw_addr = '0;
    logic [7:0]  aw_len = '0;
    logic [2:0]  aw_size = '0;
    logic [1:0]  aw_burst = '0;
    logic [4:0]  aw_id = '0;
    logic        aw_valid = 1'b0;
    logic        aw_ready;
    logic [63:0] w_data = '0;
    logic [7:0]  w_strb = '0;
    logic        w_last = 1'b0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [4:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready = 1'b0;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;
    logic        mem_gnt = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [19:0] wr_addr_q[$];
    logic [63:0] wr_data_q[$];
    logic [7:0]  wr_be_q[$];

    vstu_w_sink dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .aw_addr_i   (aw_addr),
        .aw_len_i    (aw_len),
        .aw_size_i   (aw_size),
        .aw_burst_i  (aw_burst),
        .aw_id_i     (aw_id),
        .aw_valid_i  (aw_valid),
        .aw_ready_o  (aw_ready),
        .w_data_i    (w_data),
        .w_strb_i    (w_strb),
        .w_last_i    (w_last),
        .w_valid_i   (w_valid),
        .w_ready_o   (w_ready),
        .b_id_o      (b_id),
        .b_resp_o    (b_resp),
        .b_valid_o   (b_valid),
        .b_ready_i   (b_ready),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_be_o    (mem_be),
        .mem_gnt_i   (mem_gnt)
    );

    always #5 clk = ~clk;

    // Memory writes observed mid-cycle, i.e. the ones the next edge commits.
    always @(negedge clk) begin
        if (mem_req && mem_gnt) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            wr_be_q.push_back(mem_be);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_be_q.delete();
    endtask

    task automatic send_aw(input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [4:0] id);
        int n;
        n = 0;
        aw_addr = addr; aw_len = len; aw_size = size; aw_burst = 2'b01; aw_id = id;
        aw_valid = 1'b1;
        #1;
        while (!aw_ready && n < 50) begin step(); n++; end
        if (!aw_ready) begin
            checks++; errors++;
            $display("FAIL aw_timeout got aw_ready=%b want 1", aw_ready);
        end
        step();
        aw_valid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n;
        n = 0;
        w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
        #1;
        while (!w_ready && n < 50) begin step(); n++; end
        if (!w_ready) begin
            checks++; errors++;
            $display("FAIL w_timeout got w_ready=%b want 1", w_ready);
        end
        step();
        w_valid = 1'b0; w_strb = '0; w_last = 1'b0; w_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; w_valid = 1'b1; w_strb = 8'hFF; w_data = 64'hDEAD_BEEF_0123_4567;
        repeat (3) step();
        checks++; if (aw_ready !== 1'b0) begin errors++; $display("FAIL rst_aw_ready got %b want 0", aw_ready); end
        checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL rst_w_ready got %b want 0", w_ready); end
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid got %b want 0", b_valid); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
        checks++;
        if (mem_wdata !== 64'h0 || mem_be !== 8'h0 || mem_addr !== 20'h0) begin
            errors++;
            $display("FAIL rst_data got wdata=%h be=%h addr=%h want all 0", mem_wdata, mem_be, mem_addr);
        end
        rst = 1'b0; w_valid = 1'b0; w_strb = '0; w_data = '0;
        #1;
        checks++; if (aw_ready !== 1'b1) begin errors++; $display("FAIL rst_release_aw_ready got %b want 1", aw_ready); end
        step();
    endtask

    task automatic test_single_burst();
        clear_log(); mem_gnt = 1'b1; b_ready = 1'b0;
        send_aw(64'h1000, 8'd3, 3'd3, 5'd5);
        checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL aw_to_w_bubble got w_ready=%b want 0", w_ready); end
        for (int i = 0; i < 3; i++) send_w(64'h1111_0000_0000_0000 + 64'(i), 8'hFF, 1'b0);
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL single_b_early got %b want 0", b_valid); end
        send_w(64'h1111_0000_0000_0003, 8'hFF, 1'b1);
        checks++;
        if (b_valid !== 1'b1 || b_id !== 5'd5 || b_resp !== 2'b00) begin
            errors++;
            $display("FAIL single_b got valid=%b id=%0d resp=%b want 1 5 00", b_valid, b_id, b_resp);
        end
        checks++; if (wr_addr_q.size() != 4) begin errors++; $display("FAIL single_count got %0d want 4", wr_addr_q.size()); end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== 20'h200 + 20'(i) || wr_data_q[i] !== 64'h1111_0000_0000_0000 + 64'(i)
                || wr_be_q[i] !== 8'hFF) begin
                errors++;
                $display("FAIL single_beat%0d got addr=%h data=%h be=%h want %h %h ff", i,
                         wr_addr_q[i], wr_data_q[i], wr_be_q[i], 20'h200 + 20'(i),
                         64'h1111_0000_0000_0000 + 64'(i));
            end
        end
        b_ready = 1'b1; step(); b_ready = 1'b0;
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL single_b_pop got %b want 0", b_valid); end
    endtask

    task automatic test_unaligned();
        clear_log(); b_ready = 1'b0;
        send_aw(64'h1004, 8'd1, 3'd2, 5'd6);
        send_w(64'hAAAA_BBBB_0000_0000, 8'hF0, 1'b0);
        send_w(64'h0000_0000_CCCC_DDDD, 8'h0F, 1'b1);
        checks++;
        if (wr_addr_q.size() != 2) begin
            errors++; $display("FAIL unaligned_count got %0d want 2", wr_addr_q.size());
        end else if (wr_addr_q[0] !== 20'h200 || wr_addr_q[1] !== 20'h201 ||
                     wr_be_q[0] !== 8'hF0 || wr_be_q[1] !== 8'h0F) begin
            errors++;
            $display("FAIL unaligned_addr got %h/%h be %h/%h want 200/201 f0/0f",
                     wr_addr_q[0], wr_addr_q[1], wr_be_q[0], wr_be_q[1]);
        end
        checks++;
        if (b_valid !== 1'b1 || b_id !== 5'd6 || b_resp !== 2'b00) begin
            errors++; $display("FAIL unaligned_b got valid=%b id=%0d resp=%b want 1 6 00", b_valid, b_id, b_resp);
        end
        b_ready = 1'b1; step(); b_ready = 1'b0;
    endtask

    task automatic test_last_err();
        clear_log(); b_ready = 1'b0;
        send_aw(64'h2800, 8'd2, 3'd3, 5'd7);
        send_w(64'h70, 8'hFF, 1'b0);
        send_w(64'h71, 8'hFF, 1'b1);
        send_w(64'h72, 8'hFF, 1'b0);
        checks++;
        if (wr_addr_q.size() != 3) begin
            errors++; $display("FAIL lasterr_count got %0d want 3", wr_addr_q.size());
        end else if (wr_addr_q[2] !== 20'h502 || wr_data_q[2] !== 64'h72) begin
            errors++; $display("FAIL lasterr_beat2 got %h %h want 502 72", wr_addr_q[2], wr_data_q[2]);
        end
        checks++;
        if (b_valid !== 1'b1 || b_id !== 5'd7 || b_resp !== 2'b10) begin
            errors++; $display("FAIL lasterr_b got valid=%b id=%0d resp=%b want 1 7 10", b_valid, b_id, b_resp);
        end
        b_ready = 1'b1; step(); b_ready = 1'b0;
    endtask

    task automatic test_gnt_stall();
        int bad;
        clear_log(); mem_gnt = 1'b1; b_ready = 1'b0; bad = 0;
        send_aw(64'h3000, 8'd3, 3'd3, 5'd3);
        send_w(64'hC0, 8'hFF, 1'b0);
        send_w(64'hC1, 8'hFF, 1'b0);
        mem_gnt = 1'b0; w_data = 64'hC2; w_strb = 8'hFF; w_last = 1'b0; w_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            checks++;
            if (w_ready !== 1'b0 || mem_req !== 1'b1) begin
                errors++; $display("FAIL stall_cycle%0d got w_ready=%b mem_req=%b want 0 1", i, w_ready, mem_req);
            end
            @(posedge clk); #1;
        end
        mem_gnt = 1'b1;
        #2;
        checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %b want 1", w_ready); end
        @(posedge clk); #1;
        w_valid = 1'b0;
        send_w(64'hC3, 8'hFF, 1'b1);
        checks++; if (wr_addr_q.size() != 4) begin errors++; $display("FAIL stall_count got %0d want 4", wr_addr_q.size()); end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            if (wr_addr_q[i] !== 20'h600 + 20'(i) || wr_data_q[i] !== 64'hC0 + 64'(i)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_order got %0d bad beats want 0", bad); end
        checks++;
        if (b_valid !== 1'b1 || b_id !== 5'd3 || b_resp !== 2'b00) begin
            errors++; $display("FAIL stall_b got valid=%b id=%0d resp=%b want 1 3 00", b_valid, b_id, b_resp);
        end
        b_ready = 1'b1; step(); b_ready = 1'b0;
    endtask

    task automatic test_zero_strobe();
        clear_log(); b_ready = 1'b0;
        send_aw(64'h3800, 8'd1, 3'd3, 5'd8);
        step();
        mem_gnt = 1'b0; w_data = 64'h55; w_strb = 8'h00; w_last = 1'b0; w_valid = 1'b1;
        #2;
        checks++;
        if (w_ready !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL zstrb_beat got w_ready=%b mem_req=%b want 1 0", w_ready, mem_req);
        end
        @(posedge clk); #1;
        w_valid = 1'b0; mem_gnt = 1'b1;
        send_w(64'h66, 8'hFF, 1'b1);
        checks++;
        if (wr_addr_q.size() != 1) begin
            errors++; $display("FAIL zstrb_count got %0d want 1", wr_addr_q.size());
        end else if (wr_addr_q[0] !== 20'h701 || wr_data_q[0] !== 64'h66) begin
            errors++; $display("FAIL zstrb_addr got %h %h want 701 66", wr_addr_q[0], wr_data_q[0]);
        end
        b_ready = 1'b1; step(); b_ready = 1'b0;
    endtask

    task automatic test_b_full();
        int n;
        mem_gnt = 1'b1; b_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_aw(64'h4000 + 64'(k * 8), 8'd0, 3'd3, 5'(10 + k));
            send_w(64'(k), 8'hFF, 1'b1);
        end
        send_aw(64'h4020, 8'd0, 3'd3, 5'd14);
        w_data = 64'hE4; w_strb = 8'hFF; w_last = 1'b1; w_valid = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (w_ready !== 1'b0 || mem_req !== 1'b0) begin
                errors++; $display("FAIL bfull_stall%0d got w_ready=%b mem_req=%b want 0 0", i, w_ready, mem_req);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (b_valid !== 1'b1 || b_id !== 5'd10) begin
            errors++; $display("FAIL bfull_head got valid=%b id=%0d want 1 10", b_valid, b_id);
        end
        b_ready = 1'b1; step(); b_ready = 1'b0;
        #2;
        checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL bfull_resume got %b want 1", w_ready); end
        @(posedge clk); #1;
        w_valid = 1'b0; w_strb = '0; w_last = 1'b0;
        for (int k = 1; k < 5; k++) begin
            n = 0;
            while (!b_valid && n < 20) begin step(); n++; end
            checks++;
            if (b_valid !== 1'b1 || b_id !== 5'(10 + k) || b_resp !== 2'b00) begin
                errors++; $display("FAIL bfull_order%0d got valid=%b id=%0d resp=%b want 1 %0d 00",
                                   k, b_valid, b_id, b_resp, 10 + k);
            end
            b_ready = 1'b1; step(); b_ready = 1'b0;
        end
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL bfull_drained got %b want 0", b_valid); end
    endtask

    task automatic test_reset_mid_burst();
        b_ready = 1'b0; mem_gnt = 1'b1;
        send_aw(64'h5000, 8'd3, 3'd3, 5'd2);
        send_w(64'hA0, 8'hFF, 1'b0);
        send_w(64'hA1, 8'hFF, 1'b0);
        w_data = 64'hA2; w_strb = 8'hFF; w_valid = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (w_ready !== 1'b0 || mem_req !== 1'b0 || b_valid !== 1'b0 ||
            mem_addr !== 20'h0 || mem_wdata !== 64'h0 || mem_be !== 8'h0) begin
            errors++;
            $display("FAIL midrst_outputs got w_ready=%b req=%b b_valid=%b addr=%h wdata=%h be=%h want all 0",
                     w_ready, mem_req, b_valid, mem_addr, mem_wdata, mem_be);
        end
        w_valid = 1'b0; w_strb = '0;
        step();
        clear_log();
        send_aw(64'h2000, 8'd1, 3'd3, 5'd9);
        send_w(64'hB0, 8'hFF, 1'b0);
        send_w(64'hB1, 8'hFF, 1'b1);
        checks++;
        if (wr_addr_q.size() != 2) begin
            errors++; $display("FAIL midrst_count got %0d want 2", wr_addr_q.size());
        end else if (wr_addr_q[0] !== 20'h400 || wr_addr_q[1] !== 20'h401) begin
            errors++; $display("FAIL midrst_addr got %h/%h want 400/401", wr_addr_q[0], wr_addr_q[1]);
        end
        checks++;
        if (b_valid !== 1'b1 || b_id !== 5'd9 || b_resp !== 2'b00) begin
            errors++; $display("FAIL midrst_b got valid=%b id=%0d resp=%b want 1 9 00", b_valid, b_id, b_resp);
        end
        b_ready = 1'b1; step(); b_ready = 1'b0;
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL midrst_extra_b got %b want 0", b_valid); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_unaligned();
        test_last_err();
        test_gnt_stall();
        test_zero_strobe();
        test_b_full();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
